// File: rtl/lmac_axis_pkg.sv
// rtl/lmac_axis_pkg.sv - shared AXIS beat type, Ethernet frame limits and keep helpers
package lmac_axis_pkg;

  localparam int AXIS_DW       = 64;
  localparam int AXIS_KW       = 8;
  localparam int ETH_MAX_BYTES = 1518;
  localparam int ETH_MIN_BYTES = 14;

  typedef struct packed {
    logic               last;
    logic [AXIS_KW-1:0] keep;
    logic [AXIS_DW-1:0] data;
  } axis_beat_t;

  typedef enum logic {
    WR_ACCEPT  = 1'b0,
    WR_DISCARD = 1'b1
  } wr_state_t;

  function automatic logic [3:0] keep_popcount(input logic [AXIS_KW-1:0] keep);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < AXIS_KW; i++) begin
      n = n + {3'b000, keep[i]};
    end
    return n;
  endfunction

  // Nonzero and a run of ones starting at byte 0 (01, 03, ..., FF).
  function automatic logic keep_is_tail(input logic [AXIS_KW-1:0] keep);
    logic [AXIS_KW-1:0] inc;
    inc = keep + {{(AXIS_KW-1){1'b0}}, 1'b1};
    return (keep != '0) && ((keep & inc) == '0);
  endfunction

endpackage

// File: rtl/axis_sdp_ram.sv
// rtl/axis_sdp_ram.sv - simple dual-port RAM with one-cycle registered read
module axis_sdp_ram #(
  parameter int AW = 9,
  parameter int W  = 73
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/axis_tx_frame_buffer.sv
// rtl/axis_tx_frame_buffer.sv - store-and-forward AXIS frame FIFO feeding the LMAC TX port
module axis_tx_frame_buffer
  import lmac_axis_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9,
  parameter int MAX_BYTES  = ETH_MAX_BYTES,
  parameter int MIN_BYTES  = ETH_MIN_BYTES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic [AXIS_DW-1:0]  s_axis_tdata,
  input  logic [AXIS_KW-1:0]  s_axis_tkeep,
  input  logic                s_axis_tlast,
  input  logic                s_axis_tuser,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [AXIS_DW-1:0]  m_axis_tdata,
  output logic [AXIS_KW-1:0]  m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic [DEPTH_LOG2:0] frame_cnt,
  output logic                drop_pulse,
  output logic [31:0]         drop_cnt
);

  localparam int PW = DEPTH_LOG2 + 1;
  typedef logic [PW-1:0] ptr_t;
  localparam ptr_t        PTR_ONE  = ptr_t'(1);
  localparam ptr_t        PTR_FULL = ptr_t'((1 << DEPTH_LOG2) - 1);
  localparam logic [10:0] MIN_B    = 11'(MIN_BYTES);
  localparam logic [10:0] MAX_B    = 11'(MAX_BYTES);

  wr_state_t  state, state_nxt;
  ptr_t       wr_ptr, commit_ptr, pend_ptr, rd_ptr, fetch_ptr;
  logic       commit_pend;
  logic [10:0] byte_cnt;

  logic       wr_en, frame_good, frame_drop;
  logic       overflow, keep_bad, size_ok;
  logic [11:0] byte_sum;
  logic [10:0] byte_sat;
  ptr_t       rollback_ptr;

  axis_beat_t wr_beat, ram_q, out_beat, skid_beat;
  logic       rd_en, ram_vld, out_vld, skid_vld, pop;
  logic [1:0] held;

  assign s_axis_tready = 1'b1;

  assign byte_sum = {1'b0, byte_cnt} + {8'b0, keep_popcount(s_axis_tkeep)};
  assign byte_sat = byte_sum[11] ? 11'h7FF : byte_sum[10:0];
  assign size_ok  = (byte_sat >= MIN_B) && (byte_sat <= MAX_B);
  // Capacity is measured against rd_ptr, which only moves on an output handshake,
  // so words parked in the output skid still count as occupied.
  assign overflow = ((wr_ptr - rd_ptr) == PTR_FULL);
  assign keep_bad = s_axis_tlast ? !keep_is_tail(s_axis_tkeep) : (s_axis_tkeep != '1);
  // A commit from the previous cycle may not have landed in commit_ptr yet.
  assign rollback_ptr = commit_pend ? pend_ptr : commit_ptr;

  always_comb begin
    state_nxt  = state;
    wr_en      = 1'b0;
    frame_good = 1'b0;
    frame_drop = 1'b0;
    if (s_axis_tvalid) begin
      case (state)
        WR_ACCEPT: begin
          if (s_axis_tlast) begin
            if (!overflow && !keep_bad && !s_axis_tuser && size_ok) begin
              wr_en      = 1'b1;
              frame_good = 1'b1;
            end else begin
              frame_drop = 1'b1;
            end
          end else if (overflow || keep_bad) begin
            state_nxt = WR_DISCARD;
          end else begin
            wr_en = 1'b1;
          end
        end
        WR_DISCARD: begin
          if (s_axis_tlast) begin
            frame_drop = 1'b1;
            state_nxt  = WR_ACCEPT;
          end
        end
        default: state_nxt = WR_ACCEPT;
      endcase
    end
  end

  assign wr_beat = '{last: s_axis_tlast, keep: s_axis_tkeep, data: s_axis_tdata};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WR_ACCEPT;
      wr_ptr      <= '0;
      commit_ptr  <= '0;
      pend_ptr    <= '0;
      commit_pend <= 1'b0;
      byte_cnt    <= '0;
      drop_pulse  <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (frame_drop) begin
        wr_ptr <= rollback_ptr;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (s_axis_tvalid) begin
        byte_cnt <= s_axis_tlast ? 11'd0 : byte_sat;
      end
      commit_pend <= frame_good;
      if (frame_good) begin
        pend_ptr <= wr_ptr + PTR_ONE;
      end
      if (commit_pend) begin
        commit_ptr <= pend_ptr;
      end
      drop_pulse <= frame_drop;
      if (frame_drop) begin
        drop_cnt <= drop_cnt + 32'd1;
      end
    end
  end

  axis_sdp_ram #(
    .AW (DEPTH_LOG2),
    .W  ($bits(axis_beat_t))
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr[DEPTH_LOG2-1:0]),
    .wdata (wr_beat),
    .re    (rd_en),
    .raddr (fetch_ptr[DEPTH_LOG2-1:0]),
    .rdata (ram_q)
  );

  // Output register plus skid form a 2-entry queue; a read is only issued when the
  // word it returns is guaranteed a slot, which keeps a committed frame bubble-free.
  assign pop   = out_vld && m_axis_tready;
  assign held  = {1'b0, out_vld} + {1'b0, skid_vld} + {1'b0, ram_vld};
  assign rd_en = (fetch_ptr != commit_ptr) && ((held < 2'd2) || ((held == 2'd2) && pop));

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_ptr <= '0;
      rd_ptr    <= '0;
      ram_vld   <= 1'b0;
      out_vld   <= 1'b0;
      skid_vld  <= 1'b0;
      out_beat  <= '0;
      skid_beat <= '0;
      frame_cnt <= '0;
    end else begin
      ram_vld <= rd_en;
      if (rd_en) begin
        fetch_ptr <= fetch_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        if (skid_vld) begin
          out_beat  <= skid_beat;
          skid_vld  <= ram_vld;
          skid_beat <= ram_q;
        end else begin
          out_vld  <= ram_vld;
          out_beat <= ram_q;
        end
      end else if (ram_vld) begin
        if (!out_vld) begin
          out_vld  <= 1'b1;
          out_beat <= ram_q;
        end else begin
          skid_vld  <= 1'b1;
          skid_beat <= ram_q;
        end
      end
      case ({commit_pend, pop && out_beat.last})
        2'b10:   frame_cnt <= frame_cnt + PTR_ONE;
        2'b01:   frame_cnt <= frame_cnt - PTR_ONE;
        default: frame_cnt <= frame_cnt;
      endcase
    end
  end

  assign m_axis_tvalid = out_vld;
  assign m_axis_tdata  = out_beat.data;
  assign m_axis_tkeep  = out_beat.keep;
  assign m_axis_tlast  = out_beat.last;

endmodule

// File: tb/tb_axis_tx_frame_buffer.sv
// tb/tb_axis_tx_frame_buffer.sv - directed self-checking bench for axis_tx_frame_buffer
module tb_axis_tx_frame_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [63:0] s_axis_tdata = '0;
  logic [7:0]  s_axis_tkeep = '0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tuser = 1'b0;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic [9:0]  frame_cnt;
  logic        drop_pulse;
  logic [31:0] drop_cnt;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rdy_mode = 1;
  int exp_wr = 0;
  int exp_drops = 0;
  int pulses = 0;
  int extra = 0;
  int rise_cyc = 0;
  int last_tl_cyc = 0;
  logic [72:0] sb[$];

  axis_tx_frame_buffer dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .frame_cnt     (frame_cnt),
    .drop_pulse    (drop_pulse),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b0;
        1:       m_axis_tready = 1'b1;
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin : monitor
    logic [72:0] e;
    logic in_frame;
    logic prev_tv;
    in_frame = 1'b0;
    prev_tv  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_frame = 1'b0;
        prev_tv  = 1'b0;
      end else begin
        if (drop_pulse) pulses++;
        if (in_frame) chk("no_gap", 64'(m_axis_tvalid), 64'd1);
        if (m_axis_tvalid && !prev_tv) rise_cyc = cyc;
        prev_tv = m_axis_tvalid;
        if (m_axis_tvalid && m_axis_tready) begin
          if (sb.size() == 0) begin
            extra++;
          end else begin
            e = sb.pop_front();
            chk("out_data", m_axis_tdata, e[63:0]);
            chk("out_keep", 64'(m_axis_tkeep), 64'(e[71:64]));
            chk("out_last", 64'(m_axis_tlast), 64'(e[72]));
          end
          in_frame = !m_axis_tlast;
        end
      end
    end
  end

  task automatic send_frame(input int nbytes, input logic tuser, input logic good,
                            input int kbeat, input logic [7:0] kval);
    int nb;
    int rem;
    logic [7:0] k;
    nb = (nbytes + 7) / 8;
    @(posedge clk);
    #1;
    chk("s_tready", 64'(s_axis_tready), 64'd1);
    for (int i = 0; i < nb; i++) begin
      rem = nbytes - i * 8;
      k = (rem >= 8) ? 8'hFF : (8'hFF >> (8 - rem));
      if (i == kbeat) k = kval;
      s_axis_tdata  = {$urandom, $urandom};
      s_axis_tkeep  = k;
      s_axis_tlast  = (i == nb - 1);
      s_axis_tuser  = (i == nb - 1) ? tuser : 1'b0;
      s_axis_tvalid = 1'b1;
      if (good) sb.push_back({s_axis_tlast, k, s_axis_tdata});
      @(posedge clk);
      #1;
    end
    last_tl_cyc   = cyc;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    if (good) exp_wr = (exp_wr + nb) % 1024;
    else exp_drops++;
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    while ((sb.size() != 0 || frame_cnt != 10'd0) && g < 20000) begin
      @(posedge clk);
      g++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin : stim
    int g;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_s_tready", 64'(s_axis_tready), 64'd1);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_drop_pulse", 64'(drop_pulse), 64'd0);
    chk("rst_m_tdata", m_axis_tdata, 64'd0);
    reset = 1'b0;
    rdy_mode = 1;
    repeat (2) @(posedge clk);

    // T1: 64 B good frame, latency 3 cycles after the tlast handshake
    send_frame(64, 1'b0, 1'b1, -1, 8'h00);
    drain("t1_drain");
    chk("t1_latency", 64'(rise_cyc - last_tl_cyc), 64'd3);
    chk("t1_drop_cnt", 64'(drop_cnt), 64'd0);

    // T2: 1519 B is one byte over the limit
    send_frame(1519, 1'b0, 1'b0, -1, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    chk("t2_wr_ptr", 64'(dut.wr_ptr), 64'(exp_wr));
    chk("t2_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("t2_pulses", 64'(pulses), 64'd1);
    drain("t2_drain");

    // T3: errored frame then a good one
    send_frame(60, 1'b1, 1'b0, -1, 8'h00);
    send_frame(60, 1'b0, 1'b1, -1, 8'h00);
    drain("t3_drain");
    chk("t3_drop_cnt", 64'(drop_cnt), 64'd2);

    // T4: stalled output, 7 x 512 B fit (448 words), the 8th needs word 512 of 511
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    for (int f = 0; f < 7; f++) send_frame(512, 1'b0, 1'b1, -1, 8'h00);
    send_frame(512, 1'b0, 1'b0, -1, 8'h00);
    repeat (8) @(posedge clk);
    #1;
    chk("t4_frame_cnt", 64'(frame_cnt), 64'd7);
    chk("t4_drop_cnt", 64'(drop_cnt), 64'd3);
    rdy_mode = 1;
    drain("t4_drain");
    chk("t4_frame_cnt_end", 64'(frame_cnt), 64'd0);

    // Size and keep boundaries
    send_frame(13, 1'b0, 1'b0, -1, 8'h00);
    send_frame(14, 1'b0, 1'b1, -1, 8'h00);
    send_frame(1518, 1'b0, 1'b1, -1, 8'h00);
    send_frame(64, 1'b0, 1'b0, 1, 8'h7F);
    send_frame(60, 1'b0, 1'b0, 7, 8'h05);
    send_frame(64, 1'b0, 1'b0, 7, 8'h00);
    drain("bnd_drain");
    chk("bnd_drop_cnt", 64'(drop_cnt), 64'd7);
    chk("bnd_wr_ptr", 64'(dut.wr_ptr), 64'(exp_wr));

    // T5: random back-pressure, mixed sizes
    rdy_mode = 2;
    for (int f = 0; f < 100; f++) begin
      int nbytes;
      logic tu;
      logic good;
      nbytes = int'($urandom_range(1, 400));
      tu = (f % 17 == 5);
      good = !tu && (nbytes >= 14);
      g = 0;
      while (frame_cnt > 10'd2 && g < 5000) begin
        @(posedge clk);
        g++;
      end
      send_frame(nbytes, tu, good, -1, 8'h00);
    end
    drain("t5_drain");
    chk("t5_drop_cnt", 64'(drop_cnt), 64'(exp_drops));
    chk("t5_pulses", 64'(pulses), 64'(exp_drops));

    // T6: reset in the middle of a 1500 B frame
    rdy_mode = 1;
    send_frame(1500, 1'b0, 1'b1, -1, 8'h00);
    g = 0;
    while (sb.size() >= 150 && g < 2000) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("t6_mid_frame", 64'(sb.size() < 150 && sb.size() > 0), 64'd1);
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    chk("t6_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("t6_frame_cnt", 64'(frame_cnt), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_wr = 0;
    exp_drops = 0;
    pulses = 0;
    chk("t6_drop_cnt", 64'(drop_cnt), 64'd0);
    repeat (2) @(posedge clk);
    send_frame(64, 1'b0, 1'b1, -1, 8'h00);
    drain("t6_drain");
    chk("t6_latency", 64'(rise_cyc - last_tl_cyc), 64'd3);
    chk("t6_wr_ptr", 64'(dut.wr_ptr), 64'(exp_wr));
    chk("extra_beats", 64'(extra), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
